// File: rtl/sdram_sim_mp_pkg.sv
// Shared types for the multi-port SDRAM simulation model.
// Response-stage bundle plus a constant-foldable clog2.
package sdram_sim_pkg;
  localparam int MAX_DW = 64;
  localparam int PORT_W = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  typedef struct packed {
    logic              valid;
    logic              rd;
    logic [PORT_W-1:0] port;
    logic [MAX_DW-1:0] data;
  } rsp_t;
endpackage

// File: rtl/sdram_sim_mp_if.sv
// Client bus for the multi-port SDRAM simulation model.
// Toggle handshake: a request is pending while req != ack.
interface sdram_sim_mp_if #(
  parameter int NPORTS = 4,
  parameter int DW     = 16,
  parameter int AW     = 22
);
  logic [NPORTS-1:0]      req;
  logic [NPORTS-1:0]      ack;
  logic [NPORTS-1:0]      we;
  logic [NPORTS*AW-1:0]   addr;
  logic [NPORTS*DW-1:0]   din;
  logic [NPORTS*DW/8-1:0] be;
  logic [NPORTS*DW-1:0]   dout;
  logic                   busy;

  modport master (
    output req, we, addr, din, be,
    input  ack, dout, busy
  );

  modport slave (
    input  req, we, addr, din, be,
    output ack, dout, busy
  );
endinterface

// File: rtl/sdram_sim_mp_slot_arb.sv
// Fixed-priority picker: lowest pending port owned by the
// current phase wins the slot.
module sdram_sim_slot_arb #(
  parameter int NPORTS = 4,
  parameter int SLOTS  = 2,
  parameter int PW     = 1,
  parameter int IW     = 2
) (
  input  logic [NPORTS-1:0] i_pend,
  input  logic [PW-1:0]     i_phase,
  output logic              o_gnt_valid,
  output logic [IW-1:0]     o_gnt_idx
);
  always_comb begin
    o_gnt_valid = 1'b0;
    o_gnt_idx   = '0;
    // Scan downwards so the lowest index is the last writer.
    for (int p = NPORTS - 1; p >= 0; p--) begin
      if (i_pend[p] && ((p % SLOTS) == int'(i_phase))) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx   = IW'(p);
      end
    end
  end
endmodule

// File: rtl/sdram_sim_mp.sv
// Behavioural multi-port SDRAM stand-in: time-sliced toggle
// ports sharing one word array with a fixed-latency response.
module sdram_sim_mp
  import sdram_sim_pkg::*;
#(
  parameter int    NPORTS    = 4,
  parameter int    DW        = 16,
  parameter int    AW        = 22,
  parameter int    SLOTS     = 2,
  parameter int    LAT       = 2,
  parameter string INIT_FILE = ""
) (
  input logic           mclk,
  input logic           resetn,
  input logic           clkref,
  sdram_sim_mp_if.slave bus
);
  localparam int BW = DW / 8;
  localparam int PW = (SLOTS > 1) ? clog2(SLOTS) : 1;
  localparam int IW = (NPORTS > 1) ? clog2(NPORTS) : 1;
  localparam int NS = (LAT > 0) ? LAT : 1;

  if (DW % 8 != 0 || SLOTS > NPORTS || LAT == 0 ||
      DW > MAX_DW || NPORTS > 8) begin : g_bad_cfg
    $fatal(1, "sdram_sim_mp: illegal parameter set");
  end

  logic                 r_clkref_d;
  logic [PW-1:0]        r_phase;
  logic [NPORTS-1:0]    r_ack;
  logic [NPORTS-1:0]    r_infl;
  logic [DW-1:0]        r_dout [NPORTS];
  rsp_t                 r_pipe [NS];
  logic [DW-1:0]        r_mem [2**AW];

  logic [NPORTS-1:0]    w_pend;
  logic                 w_gv;
  logic [IW-1:0]        w_gi;
  logic                 w_we;
  logic [AW-1:0]        w_addr;
  logic [DW-1:0]        w_din;
  logic [BW-1:0]        w_be;
  logic [DW-1:0]        w_rdata;
  logic [IW-1:0]        w_ri;
  logic                 w_busy;
  logic [NPORTS*DW-1:0] w_dout;

  assign w_pend  = (bus.req ^ r_ack) & ~r_infl;
  assign w_we    = bus.we[w_gi];
  assign w_addr  = bus.addr[w_gi*AW +: AW];
  assign w_din   = bus.din[w_gi*DW +: DW];
  assign w_be    = bus.be[w_gi*BW +: BW];
  assign w_rdata = r_mem[w_addr];
  assign w_ri    = IW'(r_pipe[NS-1].port);

  sdram_sim_slot_arb #(
    .NPORTS (NPORTS),
    .SLOTS  (SLOTS),
    .PW     (PW),
    .IW     (IW)
  ) u_arb (
    .i_pend      (w_pend),
    .i_phase     (r_phase),
    .o_gnt_valid (w_gv),
    .o_gnt_idx   (w_gi)
  );

  // A rising clkref realigns the slot sequence to phase 0.
  always_ff @(posedge mclk) begin
    if (!resetn) begin
      r_clkref_d <= 1'b0;
      r_phase    <= '0;
    end else begin
      r_clkref_d <= clkref;
      if ((clkref && !r_clkref_d) || SLOTS == 1 ||
          int'(r_phase) == SLOTS - 1)
        r_phase <= '0;
      else
        r_phase <= r_phase + 1'b1;
    end
  end

  // Memory is never cleared, so writes survive a reset.
  always_ff @(posedge mclk) begin
    if (resetn && w_gv && w_we) begin
      for (int i = 0; i < BW; i++) begin
        if (w_be[i])
          r_mem[w_addr][i*8 +: 8] <= w_din[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (!resetn) begin
      r_ack  <= '0;
      r_infl <= '0;
      for (int p = 0; p < NPORTS; p++) r_dout[p] <= '0;
      for (int s = 0; s < NS; s++) r_pipe[s] <= '0;
    end else begin
      r_pipe[0].valid <= w_gv;
      r_pipe[0].rd    <= ~w_we;
      r_pipe[0].port  <= PORT_W'(w_gi);
      r_pipe[0].data  <= MAX_DW'(w_rdata);
      for (int s = 1; s < NS; s++) r_pipe[s] <= r_pipe[s-1];
      if (w_gv) r_infl[w_gi] <= 1'b1;
      if (r_pipe[NS-1].valid) begin
        r_ack[w_ri]  <= ~r_ack[w_ri];
        r_infl[w_ri] <= 1'b0;
        if (r_pipe[NS-1].rd)
          r_dout[w_ri] <= DW'(r_pipe[NS-1].data);
      end
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int s = 0; s < NS; s++) w_busy = w_busy | r_pipe[s].valid;
  end

  always_comb begin
    w_dout = '0;
    for (int p = 0; p < NPORTS; p++) w_dout[p*DW +: DW] = r_dout[p];
  end

  assign bus.ack  = r_ack;
  assign bus.dout = w_dout;
  assign bus.busy = w_busy;
endmodule

// File: tb/tb_sdram_sim_mp.sv
// Bench for sdram_sim_mp: two configurations checked every cycle
// against a per-port transaction model, plus directed timing probes.
module tb_sdram_sim_mp;
  localparam int NP  = 4;
  localparam int DWT = 16;
  localparam int AWT = 16;
  localparam int S0  = 2;
  localparam int L0  = 2;
  localparam int S1  = 1;
  localparam int L1  = 4;

  logic              mclk = 1'b0;
  logic              resetn;
  logic              t_clk  [2];
  logic [NP-1:0]     t_req  [2];
  logic [NP-1:0]     t_we   [2];
  logic [NP*AWT-1:0] t_addr [2];
  logic [NP*DWT-1:0] t_din  [2];
  logic [NP*2-1:0]   t_be   [2];
  logic [NP-1:0]     w_ack  [2];
  logic [NP*DWT-1:0] w_dout [2];
  logic              w_busy [2];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int slots [2] = '{S0, S1};
  int lat   [2] = '{L0, L1};

  // Transaction-level model: one outstanding access per port.
  logic [NP-1:0]  m_ack  [2];
  logic [NP-1:0]  m_infl [2];
  logic [DWT-1:0] m_dout [2][NP];
  logic [DWT-1:0] m_data [2][NP];
  logic           m_rd   [2][NP];
  int             m_due  [2][NP];
  int             m_since [2];
  logic           m_ckp  [2];
  logic [DWT-1:0] m_mem  [2][65536];

  sdram_sim_mp_if #(.NPORTS(NP), .DW(DWT), .AW(AWT)) if0 ();
  sdram_sim_mp_if #(.NPORTS(NP), .DW(DWT), .AW(AWT)) if1 ();

  assign if0.req  = t_req[0];
  assign if0.we   = t_we[0];
  assign if0.addr = t_addr[0];
  assign if0.din  = t_din[0];
  assign if0.be   = t_be[0];
  assign if1.req  = t_req[1];
  assign if1.we   = t_we[1];
  assign if1.addr = t_addr[1];
  assign if1.din  = t_din[1];
  assign if1.be   = t_be[1];
  assign w_ack[0]  = if0.ack;
  assign w_dout[0] = if0.dout;
  assign w_busy[0] = if0.busy;
  assign w_ack[1]  = if1.ack;
  assign w_dout[1] = if1.dout;
  assign w_busy[1] = if1.busy;

  sdram_sim_mp #(
    .NPORTS(NP), .DW(DWT), .AW(AWT),
    .SLOTS(S0), .LAT(L0), .INIT_FILE("")
  ) dut0 (
    .mclk(mclk), .resetn(resetn), .clkref(t_clk[0]), .bus(if0)
  );

  sdram_sim_mp #(
    .NPORTS(NP), .DW(DWT), .AW(AWT),
    .SLOTS(S1), .LAT(L1), .INIT_FILE("")
  ) dut1 (
    .mclk(mclk), .resetn(resetn), .clkref(t_clk[1]), .bus(if1)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_step(input int d);
    logic [NP-1:0] pend;
    int ph;
    int a;
    if (!resetn) begin
      m_ack[d]   = '0;
      m_infl[d]  = '0;
      m_since[d] = 0;
      m_ckp[d]   = 1'b0;
      for (int p = 0; p < NP; p++) m_dout[d][p] = '0;
      return;
    end
    ph   = m_since[d] % slots[d];
    pend = (t_req[d] ^ m_ack[d]) & ~m_infl[d];
    for (int p = 0; p < NP; p++) begin
      if (m_infl[d][p] && m_due[d][p] == cyc) begin
        m_ack[d][p]  = ~m_ack[d][p];
        m_infl[d][p] = 1'b0;
        if (m_rd[d][p]) m_dout[d][p] = m_data[d][p];
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (pend[p] && (p % slots[d]) == ph) begin
        a = int'(t_addr[d][p*AWT +: AWT]);
        m_infl[d][p] = 1'b1;
        m_due[d][p]  = cyc + lat[d];
        m_rd[d][p]   = !t_we[d][p];
        if (t_we[d][p]) begin
          for (int b = 0; b < 2; b++)
            if (t_be[d][p*2+b])
              m_mem[d][a][b*8 +: 8] = t_din[d][p*DWT+b*8 +: 8];
        end else begin
          m_data[d][p] = m_mem[d][a];
        end
        break;
      end
    end
    if (t_clk[d] && !m_ckp[d]) m_since[d] = 0;
    else m_since[d] = m_since[d] + 1;
    m_ckp[d] = t_clk[d];
  endtask

  always @(posedge mclk) begin
    for (int d = 0; d < 2; d++) model_step(d);
    cyc = cyc + 1;
  end

  always @(negedge mclk) begin
    if (cyc > 0) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < NP; p++) begin
          chk($sformatf("ack d%0d p%0d", d, p),
              32'(w_ack[d][p]), 32'(m_ack[d][p]));
          chk($sformatf("dout d%0d p%0d", d, p),
              32'(w_dout[d][p*DWT +: DWT]), 32'(m_dout[d][p]));
        end
        chk($sformatf("busy d%0d", d),
            32'(w_busy[d]), 32'(|m_infl[d]));
      end
    end
  end

  task automatic go(input int d, input int p, input logic we,
                    input logic [15:0] a, input logic [15:0] v,
                    input logic [1:0] be);
    t_we[d][p]               = we;
    t_addr[d][p*AWT +: AWT]  = a;
    t_din[d][p*DWT +: DWT]   = v;
    t_be[d][p*2 +: 2]        = be;
    t_req[d][p]              = ~t_req[d][p];
  endtask

  task automatic wait_ack(input int d, input int p,
                          output int kb, output int ka);
    kb = -1;
    ka = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge mclk);
      if (kb < 0 && w_busy[d]) kb = k;
      if (w_ack[d][p] == t_req[d][p]) begin
        ka = k;
        break;
      end
    end
    chk($sformatf("ack_seen d%0d p%0d", d, p), 32'(ka > 0), 32'd1);
  endtask

  int kb, ka;
  int c [4];
  bit busy_bad;
  bit all_done;

  initial begin
    resetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      t_clk[d] = 1'b0; t_req[d] = '0; t_we[d] = '0;
      t_addr[d] = '0; t_din[d] = '0; t_be[d] = '0;
    end
    repeat (2) @(negedge mclk);
    chk("rst_busy", 32'(w_busy[0]), 32'd0);
    chk("rst_ack", 32'(w_ack[0]), 32'd0);
    chk("rst_dout", 32'(w_dout[0][31:0]), 32'd0);
    resetn = 1'b1;
    @(negedge mclk);

    // Full write then read on port 0.
    go(0, 0, 1'b1, 16'h1234, 16'hBEEF, 2'b11);
    wait_ack(0, 0, kb, ka);
    chk("t1_wr_lat", 32'(ka - kb), 32'd2);
    go(0, 0, 1'b0, 16'h1234, 16'h0000, 2'b00);
    wait_ack(0, 0, kb, ka);
    chk("t1_rd_lat", 32'(ka - kb), 32'd2);
    chk("t1_rd", 32'(w_dout[0][15:0]), 32'hBEEF);

    // Byte enables: low byte only, then an empty write.
    go(0, 0, 1'b1, 16'h1234, 16'hAA55, 2'b01);
    wait_ack(0, 0, kb, ka);
    go(0, 0, 1'b0, 16'h1234, 16'h0000, 2'b11);
    wait_ack(0, 0, kb, ka);
    chk("t2_be01", 32'(w_dout[0][15:0]), 32'hBE55);
    go(0, 0, 1'b1, 16'h1234, 16'h1111, 2'b00);
    wait_ack(0, 0, kb, ka);
    go(0, 0, 1'b0, 16'h1234, 16'h0000, 2'b11);
    wait_ack(0, 0, kb, ka);
    chk("t2_be00", 32'(w_dout[0][15:0]), 32'hBE55);

    // Same-phase contention between ports 0 and 2.
    go(0, 0, 1'b0, 16'h1234, 16'h0000, 2'b11);
    go(0, 1, 1'b0, 16'h1234, 16'h0000, 2'b11);
    go(0, 2, 1'b1, 16'h0100, 16'h0F0F, 2'b11);
    c = '{-1, -1, -1, -1};
    for (int k = 1; k <= 40; k++) begin
      @(negedge mclk);
      for (int p = 0; p < 3; p++)
        if (c[p] < 0 && w_ack[0][p] == t_req[0][p]) c[p] = k;
      if (c[0] > 0 && c[1] > 0 && c[2] > 0) break;
    end
    chk("t3_p2_after_p0", 32'(c[2] - c[0]), 32'd2);
    chk("t3_p1_before_p2", 32'(c[1] > 0 && c[1] < c[2]), 32'd1);
    chk("t3_rd0", 32'(w_dout[0][15:0]), 32'hBE55);

    // clkref rises while phase 0 is due: port 1 waits one slot more.
    for (int k = 0; k < 4 && (m_since[0] % S0) != 0; k++)
      @(negedge mclk);
    t_clk[0] = 1'b1;
    go(0, 1, 1'b0, 16'h0100, 16'h0000, 2'b11);
    wait_ack(0, 1, kb, ka);
    chk("t4_realign_wait", 32'(kb), 32'd3);
    chk("t4_rd", 32'(w_dout[0][31:16]), 32'h0F0F);
    t_clk[0] = 1'b0;

    // Reset while a port 3 read is in flight.
    go(0, 3, 1'b1, 16'h0010, 16'h5A5A, 2'b11);
    wait_ack(0, 3, kb, ka);
    go(0, 3, 1'b0, 16'h0010, 16'h0000, 2'b11);
    kb = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge mclk);
      if (w_busy[0]) begin
        kb = k;
        break;
      end
    end
    chk("t5_accepted", 32'(kb > 0), 32'd1);
    resetn   = 1'b0;
    t_req[0] = 4'b0001;
    t_req[1] = '0;
    go(0, 0, 1'b0, 16'h1234, 16'h0000, 2'b11);
    t_req[0][0] = 1'b1;
    @(negedge mclk);
    chk("t5_busy", 32'(w_busy[0]), 32'd0);
    chk("t5_ack3", 32'(w_ack[0][3]), 32'd0);
    chk("t5_dout3", 32'(w_dout[0][63:48]), 32'd0);
    resetn = 1'b1;
    wait_ack(0, 0, kb, ka);
    chk("t5_pend_at_release", 32'(w_dout[0][15:0]), 32'hBE55);
    go(0, 3, 1'b0, 16'h0010, 16'h0000, 2'b11);
    wait_ack(0, 3, kb, ka);
    chk("t5_persist", 32'(w_dout[0][63:48]), 32'h5A5A);

    // Single-slot, long-latency config: one acceptance per cycle.
    for (int p = 0; p < NP; p++)
      go(1, p, 1'b1, 16'h0020 + 16'(p), 16'hC000 + 16'(p), 2'b11);
    c = '{-1, -1, -1, -1};
    kb = -1;
    busy_bad = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge mclk);
      if (kb < 0 && w_busy[1]) kb = k;
      for (int p = 0; p < NP; p++)
        if (c[p] < 0 && w_ack[1][p] == t_req[1][p]) c[p] = k;
      all_done = (c[0] > 0 && c[1] > 0 && c[2] > 0 && c[3] > 0);
      if (kb > 0 && !all_done && !w_busy[1]) busy_bad = 1'b1;
      if (all_done) break;
    end
    chk("t6_first_accept", 32'(kb), 32'd1);
    chk("t6_lat4", 32'(c[0] - kb), 32'd4);
    for (int p = 1; p < NP; p++)
      chk($sformatf("t6_spacing p%0d", p), 32'(c[p] - c[0]), 32'(p));
    chk("t6_busy_held", 32'(busy_bad), 32'd0);

    // Prefill the random-traffic address pool on both configs.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        go(d, 0, 1'b1, 16'h0040 + 16'(i), 16'($urandom), 2'b11);
        wait_ack(d, 0, kb, ka);
      end
    end

    for (int it = 0; it < 600; it++) begin
      @(negedge mclk);
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(0, 199) == 0) resetn = 1'b0;
      for (int d = 0; d < 2; d++) begin
        t_clk[d] = ($urandom_range(0, 7) == 0);
        for (int p = 0; p < NP; p++) begin
          if (t_req[d][p] == m_ack[d][p] && !m_infl[d][p] &&
              $urandom_range(0, 3) == 0)
            go(d, p, 1'($urandom_range(0, 1)),
               16'h0040 + 16'($urandom_range(0, 7)),
               16'($urandom), 2'($urandom_range(0, 3)));
        end
      end
    end

    resetn   = 1'b1;
    t_clk[0] = 1'b0;
    t_clk[1] = 1'b0;
    repeat (30) @(negedge mclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
